// File: rtl/bus_initiator.sv
// bus_initiator: turns a single-beat host command into a timed SETUP/STROBE/HOLD
// cycle on the async-style peripheral bus. Optional macro BUS_WAIT_EN adds wait_n.
module bus_initiator #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data,
  output logic              ce_n,
  output logic              read_n,
  output logic              write_n
`ifdef BUS_WAIT_EN
  ,
  input  logic              wait_n
`endif
);

  localparam int MAX_CYC = (SETUP_CYC > STROBE_CYC) ?
                           ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                           ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                write_q, write_d;
  logic                drive_q, drive_d;
  logic                ce_n_q, ce_n_d;
  logic                read_n_q, read_n_d;
  logic                write_n_q, write_n_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                strobe_hold;

`ifdef BUS_WAIT_EN
  assign strobe_hold = ~wait_n;
`else
  assign strobe_hold = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    drive_d     = drive_q;
    ce_n_d      = ce_n_q;
    read_n_d    = read_n_q;
    write_n_d   = write_n_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d     = SETUP;
          cnt_d       = SETUP_LD;
          write_d     = cmd_write;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          drive_d     = cmd_write;
          ce_n_d      = 1'b0;
          cmd_ready_d = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d   = STROBE;
          cnt_d     = STROBE_LD;
          read_n_d  = write_q;
          write_n_d = ~write_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STROBE: begin
        // Read data is sampled on the exit edge, while read_n is still low.
        if (cnt_q == '0) begin
          if (!strobe_hold) begin
            state_d   = HOLD;
            cnt_d     = HOLD_LD;
            read_n_d  = 1'b1;
            write_n_d = 1'b1;
            if (!write_q) rsp_rdata_d = data;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d     = IDLE;
          ce_n_d      = 1'b1;
          drive_d     = 1'b0;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      drive_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      read_n_q    <= 1'b1;
      write_n_q   <= 1'b1;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      drive_q     <= drive_d;
      ce_n_q      <= ce_n_d;
      read_n_q    <= read_n_d;
      write_n_q   <= write_n_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      addr_q      <= addr_d;
    end
    wdata_q <= wdata_d;
  end

  assign data      = drive_q ? wdata_q : {DATA_W{1'bz}};
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign addr      = addr_q;
  assign ce_n      = ce_n_q;
  assign read_n    = read_n_q;
  assign write_n   = write_n_q;

endmodule
